npu_cmd_ctrl: RTL

- Sits directly downstream of the SPI slave in the clk domain.
- Consumes the decoded command fields (cmd, tile_i, tile_j, op_code, data_in, valid) and executes one command per SPI frame.
- Commands write or read an 8x8 byte tile buffer, launch a compute op on the NPU core, or report status.
- Drives data_out back to the SPI slave for readback on the next frame.

---
 rtl/npu_cmd_ctrl_if.sv | 39 +++
 rtl/npu_cmd_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/npu_cmd_ctrl_if.sv
// Bundles the SPI-side command fields and the NPU core port of npu_cmd_ctrl.
// The slave modport belongs to the controller; the master modport drives it.
interface npu_cmd_ctrl_if #(
  parameter int TILE_DIM = 8,
  parameter int DATA_W   = 8
);
  localparam int IDX_W = $clog2(TILE_DIM);

  // SPI slave side
  logic [7:0]         cmd;
  logic [IDX_W-1:0]   tile_i;
  logic [IDX_W-1:0]   tile_j;
  logic [2:0]         op_code;
  logic [DATA_W-1:0]  data_in;
  logic               valid;
  logic [DATA_W-1:0]  data_out;
  logic               busy;

  // NPU core side
  logic               core_start;
  logic [2:0]         core_op;
  logic               core_done;
  logic [2*IDX_W-1:0] core_addr;
  logic [DATA_W-1:0]  core_rdata;
  logic               core_we;
  logic [DATA_W-1:0]  core_wdata;

  modport slave (
    input  cmd, tile_i, tile_j, op_code, data_in, valid,
    input  core_done, core_addr, core_we, core_wdata,
    output data_out, busy, core_start, core_op, core_rdata
  );

  modport master (
    output cmd, tile_i, tile_j, op_code, data_in, valid,
    output core_done, core_addr, core_we, core_wdata,
    input  data_out, busy, core_start, core_op, core_rdata
  );
endinterface

// File: rtl/npu_cmd_ctrl.sv
// Command controller between the SPI slave and the NPU core: executes one
// command per SPI frame against an 8x8 tile buffer and sequences core ops.
module npu_cmd_ctrl #(
  parameter int TILE_DIM = 8,
  parameter int DATA_W   = 8,
  parameter int TIMEOUT  = 1024
) (
  input logic            clk,
  input logic            rst,
  npu_cmd_ctrl_if.slave  bus
);
  localparam int IDX_W  = $clog2(TILE_DIM);
  localparam int ADDR_W = 2 * IDX_W;
  localparam int DEPTH  = TILE_DIM * TILE_DIM;
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_START  = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cmd_busy_q, cmd_busy_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                core_start_q, core_start_d;
  logic [2:0]          core_op_q, core_op_d;
  logic [2:0]          last_op_q, last_op_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic frame_end, start_ok, wait_exit;
  logic done_set, err_set, tmo_set, flags_clr;

  assign frame_end = valid_q & ~bus.valid;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    valid_d      = bus.valid;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    cmd_busy_d   = cmd_busy_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    core_op_d    = core_op_q;
    last_op_d    = last_op_q;
    data_out_d   = data_out_q;
    core_rdata_d = mem[bus.core_addr];
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    mem_wdata    = wdata_q;
    start_ok     = 1'b0;
    wait_exit    = 1'b0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    tmo_set      = 1'b0;
    flags_clr    = 1'b0;

    case (state_q)
      IDLE: if (frame_end) state_d = EXEC;

      EXEC: begin
        // cmd_busy_q marks frames that arrived during a core op; they run
        // after it finishes but still obey the busy restrictions.
        case (cmd_q)
          CMD_WRITE:  if (cmd_busy_q) err_set = 1'b1; else mem_we = 1'b1;
          CMD_READ:   data_out_d = mem[addr_q];
          CMD_START:  if (cmd_busy_q) err_set = 1'b1; else start_ok = 1'b1;
          CMD_STATUS: begin
            data_out_d = {busy_q, done_q, err_q, tmo_q, 1'b0, last_op_q};
            flags_clr  = 1'b1;
          end
          default:    err_set = 1'b1;
        endcase
        if (start_ok) begin
          core_start_d = 1'b1;
          core_op_d    = op_q;
          last_op_d    = op_q;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT_DONE;
          if (frame_end) pend_d = 1'b1;
        end else begin
          state_d = frame_end ? EXEC : IDLE;
        end
      end

      WAIT_DONE: begin
        if (frame_end) begin
          pend_d = 1'b1;
          if (pend_q) err_set = 1'b1;
        end
        if (bus.core_done) begin
          done_set  = 1'b1;
          wait_exit = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_set   = 1'b1;
          wait_exit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (wait_exit) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = (pend_q || frame_end) ? EXEC : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      cmd_d      = bus.cmd;
      addr_d     = {bus.tile_i, bus.tile_j};
      op_d       = bus.op_code;
      wdata_d    = bus.data_in;
      cmd_busy_d = busy_q | start_ok;
    end

    // Core writes only land while busy, and SPI writes only execute when not.
    if (bus.core_we && busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = bus.core_addr;
      mem_wdata = bus.core_wdata;
    end

    done_d = (done_q & ~flags_clr) | done_set;
    err_d  = (err_q  & ~flags_clr) | err_set;
    tmo_d  = (tmo_q  & ~flags_clr) | tmo_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      wdata_q      <= '0;
      cmd_busy_q   <= 1'b0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      core_op_q    <= '0;
      last_op_q    <= '0;
      data_out_q   <= '0;
      core_rdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      cmd_busy_q   <= cmd_busy_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      core_op_q    <= core_op_d;
      last_op_q    <= last_op_d;
      data_out_q   <= data_out_d;
      core_rdata_q <= core_rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  // NOTE: the tile buffer has no reset so it maps onto plain RAM; its
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.data_out   = data_out_q;
  assign bus.busy       = busy_q;
  assign bus.core_start = core_start_q;
  assign bus.core_op    = core_op_q;
  assign bus.core_rdata = core_rdata_q;
endmodule
